// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the cache line to burst-memory adaptor.
package cache_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one line-wide pmem read/write into a fixed 4-beat burst on the bmem port.
// Build macro CACHELINE_ADAPTOR_ERR_EN adds a sticky proto_err output.
module cacheline_adaptor
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [ADDR_W-1:0]  bmem_address,
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [BURST_W-1:0] bmem_wdata,
  input  logic [BURST_W-1:0] bmem_rdata,
  input  logic               bmem_resp
`ifdef CACHELINE_ADAPTOR_ERR_EN
  ,
  output logic               proto_err
`endif
);

  adaptor_state_t    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [LINE_W-1:0] wbuf_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;
  logic              last_beat;
  logic              unused_addr_bits;

  assign cnt_d            = cnt_q + CNT_W'(1);
  assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));
  assign unused_addr_bits = ^pmem_address[OFFSET_W-1:0];

  // Line with the current read beat merged in; beat 0 lands in the LSBs.
  always_comb begin
    line_d = line_q;
    line_d[int'(cnt_q) * BURST_W +: BURST_W] = bmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pmem_resp    <= 1'b0;
      bmem_read    <= 1'b0;
      bmem_write   <= 1'b0;
      bmem_address <= '0;
      bmem_wdata   <= '0;
      pmem_rdata   <= '0;
      wbuf_q       <= '0;
      line_q       <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pmem_write || pmem_read) begin
            bmem_address <= {pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            wbuf_q       <= pmem_wdata;
            cnt_q        <= '0;
            // Write wins when both requests are raised together.
            if (pmem_write) begin
              state_q    <= WRITE;
              bmem_write <= 1'b1;
              bmem_wdata <= pmem_wdata[BURST_W-1:0];
            end else begin
              state_q   <= READ;
              bmem_read <= 1'b1;
            end
          end
        end
        READ: begin
          if (bmem_resp) begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
            if (last_beat) begin
              pmem_rdata <= line_d;
              bmem_read  <= 1'b0;
              pmem_resp  <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        WRITE: begin
          if (bmem_resp) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              bmem_write <= 1'b0;
              pmem_resp  <= 1'b1;
              state_q    <= DONE;
            end else begin
              bmem_wdata <= wbuf_q[int'(cnt_d) * BURST_W +: BURST_W];
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if ((state_q == IDLE  && ((pmem_read && pmem_write) || bmem_resp)) ||
                 (state_q == READ  && !pmem_read) ||
                 (state_q == WRITE && !pmem_write)) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, corner sequences, random traffic
// against a line-level reference memory.
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               pmem_read, pmem_write;
  logic [31:0]        pmem_address;
  logic [LINE_W-1:0]  pmem_wdata, pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        bmem_address;
  logic               bmem_read, bmem_write;
  logic [BURST_W-1:0] bmem_wdata, bmem_rdata;
  logic               bmem_resp;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic               proto_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int resp_count = 0;

  logic [63:0]  mem      [logic [31:0]];
  logic [255:0] ref_line [logic [31:0]];

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           stall;
    logic [31:0]  exp_addr;
    int           exp_lat;
    bit           chk_rd;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  cacheline_adaptor #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp)
`ifdef CACHELINE_ADAPTOR_ERR_EN
    ,
    .proto_err    (proto_err)
`endif
  );

  always @(negedge clk) if (!rst && pmem_resp) resp_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [63:0] def_word(input logic [31:0] a);
    return {32'hC0DE_0000 ^ a, ~a};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return def_word(a);
  endfunction

  function automatic logic [255:0] ref_read(input logic [31:0] line);
    logic [255:0] r;
    if (ref_line.exists(line)) return ref_line[line];
    for (int b = 0; b < 4; b++) r[b*64 +: 64] = def_word(line + 32'(b * 8));
    return r;
  endfunction

  // Drives one request and plays the burst memory; exp_lat < 0 means 5 + injected stalls.
  task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input int stall, input bit stall_rnd,
                         input bit hold, input logic [31:0] exp_addr, input int exp_lat,
                         input bit chk_rd, input logic [255:0] exp_rdata);
    int beat = 0, cyc = 0, stall_left, stalls = 0, wd_err = 0, lat = 0;
    bit done = 0;
    logic [31:0]  baddr = '0;
    logic [255:0] rdata = '0;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wdata; bmem_resp = 1'b0;
    stall_left = stall_rnd ? $urandom_range(stall, 0) : stall;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bmem_resp = 1'b0;
      if (pmem_resp) begin
        done = 1; lat = cyc; rdata = pmem_rdata;
        if (!hold) begin pmem_read = 1'b0; pmem_write = 1'b0; end
      end else if (bmem_read || bmem_write) begin
        if (beat == 0) baddr = bmem_address;
        if (bmem_write && beat < 4 && bmem_wdata !== wdata[beat*64 +: 64]) wd_err++;
        if (stall_left > 0) begin
          stall_left--; stalls++;
        end else begin
          bmem_resp = 1'b1;
          if (bmem_write) mem[bmem_address + 32'(beat * 8)] = bmem_wdata;
          else            bmem_rdata = mem_rd(bmem_address + 32'(beat * 8));
          beat++;
          stall_left = stall_rnd ? $urandom_range(stall, 0) : stall;
        end
      end
    end
    if (!done) begin
      pmem_read = 1'b0; pmem_write = 1'b0;
      check({tag, " timeout"}, 0, 1);
    end else begin
      @(negedge clk);
      check({tag, " resp one cycle"}, pmem_resp, 0);
      check({tag, " beats"}, beat, 4);
      check({tag, " bmem_address"}, baddr, exp_addr);
      check({tag, " latency"}, lat, (exp_lat < 0) ? 5 + stalls : exp_lat);
      if (wr) check({tag, " wdata beat errors"}, wd_err, 0);
      if (chk_rd) check({tag, " rdata"}, rdata, exp_rdata);
    end
  endtask

  initial begin
    logic [31:0]  a;
    logic [255:0] wd;
    bit           w;
    int           base, beats, cyc;

    vecs[0] = '{1, 0, 32'h1234_5678, '0, 0, 32'h1234_5660, 5, 1,
                {64'hD, 64'hC, 64'hB, 64'hA}};
    vecs[1] = '{0, 1, 32'h0000_0047,
                {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001},
                2, 32'h0000_0040, 13, 0, '0};
    vecs[2] = '{1, 0, 32'h0000_005F, '0, 1, 32'h0000_0040, 9, 1,
                {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001}};
    vecs[3] = '{1, 1, 32'h8000_0081,
                {64'hA5A5_0003_0000_0003, 64'hA5A5_0002_0000_0002,
                 64'hA5A5_0001_0000_0001, 64'hA5A5_0000_0000_0000},
                0, 32'h8000_0080, 5, 0, '0};
    vecs[4] = '{1, 0, 32'h8000_009C, '0, 0, 32'h8000_0080, 5, 1,
                {64'hA5A5_0003_0000_0003, 64'hA5A5_0002_0000_0002,
                 64'hA5A5_0001_0000_0001, 64'hA5A5_0000_0000_0000}};
    vecs[5] = '{0, 1, 32'hFFFF_FFFF,
                {64'h0F0F_F0F0_1234_0004, 64'h0F0F_F0F0_1234_0003,
                 64'h0F0F_F0F0_1234_0002, 64'h0F0F_F0F0_1234_0001},
                1, 32'hFFFF_FFE0, 9, 0, '0};

    mem[32'h1234_5660] = 64'hA;
    mem[32'h1234_5668] = 64'hB;
    mem[32'h1234_5670] = 64'hC;
    mem[32'h1234_5678] = 64'hD;
    ref_line[32'h1234_5660] = {64'hD, 64'hC, 64'hB, 64'hA};

    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
    pmem_wdata = '0; bmem_resp = 1'b0; bmem_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset pmem_resp", pmem_resp, 0);
    check("reset bmem_read", bmem_read, 0);
    check("reset bmem_write", bmem_write, 0);
    check("reset bmem_address", bmem_address, 0);
    check("reset bmem_wdata", bmem_wdata, 0);
    check("reset pmem_rdata", pmem_rdata, 0);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("reset proto_err", proto_err, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].stall, 0, 0, vecs[i].exp_addr, vecs[i].exp_lat,
              vecs[i].chk_rd, vecs[i].exp_rdata);
      if (vecs[i].wr) ref_line[align(vecs[i].addr)] = vecs[i].wdata;
`ifdef CACHELINE_ADAPTOR_ERR_EN
      if (i == 3) check("proto_err after read&write", proto_err, 1);
`endif
    end
    check("table resp pulses", resp_count, 6);

    // bmem_resp while idle must not start or advance anything.
    bmem_resp = 1'b1;
    repeat (3) @(negedge clk);
    check("idle bmem_resp no pmem_resp", pmem_resp, 0);
    check("idle bmem_resp no burst", {bmem_read, bmem_write}, 0);
    bmem_resp = 1'b0;

    // Request held through DONE: exactly one new burst, no second response in DONE.
    base = resp_count;
    run_txn("hold1", 1, 0, 32'h1234_5660, '0, 0, 0, 1, 32'h1234_5660, 5, 1, ref_read(32'h1234_5660));
    run_txn("hold2", 1, 0, 32'h1234_5660, '0, 0, 0, 0, 32'h1234_5660, 5, 1, ref_read(32'h1234_5660));
    check("hold resp pulses", resp_count - base, 2);

    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(1, 0));
      a  = 32'h0000_0200 + 32'($urandom_range(3, 0)) * 32'h20 + 32'($urandom_range(31, 0));
      wd = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      run_txn("rand", !w, w, a, wd, 2, 1, 0, align(a), -1, !w, ref_read(align(a)));
      if (w) ref_line[align(a)] = wd;
    end

    // Reset after two accepted read beats aborts the burst.
    pmem_read = 1'b1; pmem_address = 32'h0000_0100; bmem_resp = 1'b0;
    beats = 0; cyc = 0;
    while (beats < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bmem_resp = 1'b0;
      if (bmem_read) begin
        bmem_resp  = 1'b1;
        bmem_rdata = mem_rd(bmem_address + 32'(beats * 8));
        beats++;
      end
    end
    check("midburst beats before reset", beats, 2);
    @(negedge clk);
    bmem_resp = 1'b0;
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("proto_err sticky before rst", proto_err, 1);
`endif
    rst = 1'b1; pmem_read = 1'b0;
    @(negedge clk);
    check("midburst rst bmem_read", bmem_read, 0);
    check("midburst rst pmem_resp", pmem_resp, 0);
    check("midburst rst bmem_address", bmem_address, 0);
    check("midburst rst pmem_rdata", pmem_rdata, 0);
`ifdef CACHELINE_ADAPTOR_ERR_EN
    check("proto_err cleared by rst", proto_err, 0);
`endif
    rst = 1'b0;
    run_txn("after rst", 1, 0, 32'h0000_0110, '0, 0, 0, 0, 32'h0000_0100, 5, 1,
            ref_read(32'h0000_0100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
